// File: rtl/hsm_uart_port.sv
// hsm_uart_port: UART transceiver with RTS/CTS flow control and a show-ahead RX FIFO.
// The serial side is rx/cts in and tx/rts out. The firmware side uses valid/ready byte streams.
// Optional feature macro: HSM_UART_PARITY_EN adds an even-parity bit after the data bits.
// Without it, frames are start + DATA_BITS + stop.
module hsm_uart_port #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int RX_DEPTH   = 16,
    parameter int RTS_MARGIN = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 rx,
    input  logic                 cts,
    output logic                 tx,
    output logic                 rts,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    output logic                 rx_frame_err
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(RX_DEPTH);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   RTS_LEVEL = (AW + 1)'(RX_DEPTH - RTS_MARGIN);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(RX_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef HSM_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers: bit 1 = cts, bit 0 = rx. Both idle high.
    // ------------------------------------------------------------------
    logic [1:0] async_in;
    logic [1:0] sync_vec;
    logic       cts_sync;
    logic       rx_sync;

    assign async_in = {cts, rx};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic stage1_reg;
            logic stage2_reg;
            // Two-flop synchroniser, resets to the idle (high) level
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    stage1_reg <= 1'b1;
                    stage2_reg <= 1'b1;
                end else begin
                    stage1_reg <= async_in[gi];
                    stage2_reg <= stage1_reg;
                end
            end
            assign sync_vec[gi] = stage2_reg;
        end
    endgenerate

    assign cts_sync = sync_vec[1];
    assign rx_sync  = sync_vec[0];

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t                 tx_state_reg, tx_state_next;
    logic [CW-1:0]          tx_cnt_reg, tx_cnt_next;
    logic [BW-1:0]          tx_bit_reg, tx_bit_next;
    logic [DATA_BITS-1:0]   tx_shift_reg, tx_shift_next;
    logic                   tx_reg, tx_next;
    logic                   tx_wrap;
`ifdef HSM_UART_PARITY_EN
    logic                   tx_par_reg, tx_par_next;
`endif

    assign tx_wrap  = (tx_cnt_reg == CNT_LAST);
    assign tx_ready = (tx_state_reg == S_IDLE) && !cts_sync;
    assign tx       = tx_reg;

    // TX state register and datapath registers; tx line is registered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state_reg <= S_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_reg       <= 1'b1;
`ifdef HSM_UART_PARITY_EN
            tx_par_reg   <= 1'b0;
`endif
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_reg       <= tx_next;
`ifdef HSM_UART_PARITY_EN
            tx_par_reg   <= tx_par_next;
`endif
        end
    end

    // TX next-state: each state lasts CLK_DIV cycles, data shifts out LSB first
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
`ifdef HSM_UART_PARITY_EN
        tx_par_next   = tx_par_reg;
`endif
        case (tx_state_reg)
            S_IDLE: begin
                tx_cnt_next = '0;
                if (tx_valid && tx_ready) begin
                    tx_state_next = S_START;
                    tx_shift_next = tx_data;
`ifdef HSM_UART_PARITY_EN
                    tx_par_next   = ^tx_data;
`endif
                end
            end
            S_START: begin
                tx_cnt_next = tx_wrap ? '0 : tx_cnt_reg + CW'(1);
                if (tx_wrap) begin
                    tx_state_next = S_DATA;
                    tx_bit_next   = '0;
                end
            end
            S_DATA: begin
                tx_cnt_next = tx_wrap ? '0 : tx_cnt_reg + CW'(1);
                if (tx_wrap) begin
                    tx_shift_next = tx_shift_reg >> 1;
                    if (tx_bit_reg == BIT_LAST) begin
`ifdef HSM_UART_PARITY_EN
                        tx_state_next = S_PARITY;
`else
                        tx_state_next = S_STOP;
`endif
                    end else begin
                        tx_bit_next = tx_bit_reg + BW'(1);
                    end
                end
            end
`ifdef HSM_UART_PARITY_EN
            S_PARITY: begin
                tx_cnt_next = tx_wrap ? '0 : tx_cnt_reg + CW'(1);
                if (tx_wrap) tx_state_next = S_STOP;
            end
`endif
            S_STOP: begin
                tx_cnt_next = tx_wrap ? '0 : tx_cnt_reg + CW'(1);
                if (tx_wrap) tx_state_next = S_IDLE;
            end
            default: begin
                tx_state_next = S_IDLE;
                tx_cnt_next   = '0;
            end
        endcase
    end

    // TX output: line level for the state being entered
    always_comb begin
        tx_next = 1'b1;
        case (tx_state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = tx_shift_next[0];
`ifdef HSM_UART_PARITY_EN
            S_PARITY: tx_next = tx_par_next;
`endif
            default:  tx_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    state_t                 rx_state_reg, rx_state_next;
    logic [CW-1:0]          rx_cnt_reg, rx_cnt_next;
    logic [BW-1:0]          rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0]   rx_shift_reg, rx_shift_next;
    logic                   rx_perr_reg, rx_perr_next;
    logic                   rx_prev_reg;
    logic                   rx_wrap;
    logic                   rx_fall;
    logic                   stop_sample;
    logic                   push_req;
    logic                   frame_err_next;
    logic                   overrun_next;
    logic                   frame_err_reg;
    logic                   overrun_reg;

    assign rx_wrap = (rx_cnt_reg == CNT_LAST);
    assign rx_fall = rx_prev_reg && !rx_sync;

    // RX state register, sample shift register and error pulse registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state_reg  <= S_IDLE;
            rx_cnt_reg    <= '0;
            rx_bit_reg    <= '0;
            rx_shift_reg  <= '0;
            rx_perr_reg   <= 1'b0;
            rx_prev_reg   <= 1'b1;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            rx_state_reg  <= rx_state_next;
            rx_cnt_reg    <= rx_cnt_next;
            rx_bit_reg    <= rx_bit_next;
            rx_shift_reg  <= rx_shift_next;
            rx_perr_reg   <= rx_perr_next;
            rx_prev_reg   <= rx_sync;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    // RX next-state: start validated at half a bit, then one sample per bit period
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_perr_next  = rx_perr_reg;
        case (rx_state_reg)
            S_IDLE: begin
                rx_cnt_next = '0;
                if (rx_fall) rx_state_next = S_START;
            end
            S_START: begin
                rx_perr_next = 1'b0;
                if (rx_cnt_reg == CNT_HALF) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + CW'(1);
                end
            end
            S_DATA: begin
                rx_cnt_next = rx_wrap ? '0 : rx_cnt_reg + CW'(1);
                if (rx_wrap) begin
                    rx_shift_next = {rx_sync, rx_shift_reg[DATA_BITS-1:1]};
                    if (rx_bit_reg == BIT_LAST) begin
`ifdef HSM_UART_PARITY_EN
                        rx_state_next = S_PARITY;
`else
                        rx_state_next = S_STOP;
`endif
                    end else begin
                        rx_bit_next = rx_bit_reg + BW'(1);
                    end
                end
            end
`ifdef HSM_UART_PARITY_EN
            S_PARITY: begin
                rx_cnt_next = rx_wrap ? '0 : rx_cnt_reg + CW'(1);
                if (rx_wrap) begin
                    rx_perr_next  = (^rx_shift_reg) ^ rx_sync;
                    rx_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                rx_cnt_next = rx_wrap ? '0 : rx_cnt_reg + CW'(1);
                if (rx_wrap) rx_state_next = S_IDLE;
            end
            default: begin
                rx_state_next = S_IDLE;
                rx_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX FIFO with registered show-ahead read
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [RX_DEPTH];
    logic [AW-1:0]        wptr_reg, rptr_reg;
    logic [AW:0]          count_reg;
    logic [DATA_BITS-1:0] rdata_reg;
    logic [AW-1:0]        rd_addr;
    logic                 rts_reg;
    logic                 fifo_full;
    logic                 pop;
    logic                 push_ok;

    assign fifo_full = (count_reg == FIFO_FULL);
    assign rx_valid  = (count_reg != '0);
    assign pop       = rx_valid && rx_ready;
    assign rd_addr   = pop ? rptr_reg + AW'(1) : rptr_reg;

    // RX output: stop-bit decision, push request and error pulses
    always_comb begin
        stop_sample    = (rx_state_reg == S_STOP) && rx_wrap;
        push_req       = stop_sample && rx_sync && !rx_perr_reg;
        frame_err_next = stop_sample && !push_req;
        push_ok        = push_req && (!fifo_full || pop);
        overrun_next   = push_req && fifo_full && !pop;
    end

    // FIFO storage write and head register; head bypasses a write to the slot being read
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_reg] <= rx_shift_reg;
        rdata_reg <= (push_ok && (wptr_reg == rd_addr)) ? rx_shift_reg : mem[rd_addr];
    end

    // FIFO pointers, occupancy and registered rts watermark
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            rts_reg   <= 1'b1;
        end else begin
            if (push_ok) wptr_reg <= wptr_reg + AW'(1);
            if (pop)     rptr_reg <= rptr_reg + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            rts_reg <= !(count_reg < RTS_LEVEL);
        end
    end

    assign rx_data      = rdata_reg;
    assign rts          = rts_reg;
    assign rx_overrun   = overrun_reg;
    assign rx_frame_err = frame_err_reg;

endmodule

// File: tb/tb_hsm_uart_port.sv
// Directed bench for hsm_uart_port (CLK_DIV=4, DATA_BITS=8, RX_DEPTH=4, RTS_MARGIN=1).
// Build with HSM_UART_PARITY_EN defined to also exercise the parity path.
module tb_hsm_uart_port;

    logic       clk;
    logic       resetn;
    logic       rx_drv;
    logic       loop_en;
    logic       rx_line;
    logic       cts;
    logic       tx;
    logic       rts;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_overrun;
    logic       rx_frame_err;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
`ifdef HSM_UART_PARITY_EN
    logic par_flip = 1'b0;
`endif

    assign rx_line = loop_en ? tx : rx_drv;

    hsm_uart_port #(
        .CLK_DIV    (4),
        .DATA_BITS  (8),
        .RX_DEPTH   (4),
        .RTS_MARGIN (1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rx           (rx_line),
        .cts          (cts),
        .tx           (tx),
        .rts          (rts),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_frame_err) fe_cnt <= fe_cnt + 1;
        if (rx_overrun)   ov_cnt <= ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        wait_ready(ok);
        check("send_ready", ok, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        $display("tx byte 0x%02h accepted", b);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (4) @(negedge clk);
        end
`ifdef HSM_UART_PARITY_EN
        rx_drv = (^d) ^ par_flip;
        repeat (4) @(negedge clk);
`endif
        rx_drv = stop_bit;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (8) @(negedge clk);
        $display("rx frame 0x%02h stop=%0d injected", d, stop_bit);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, rx_valid, 1);
        check({tag, "_data"}, rx_data, exp);
        $display("pop %s data=0x%02h", tag, rx_data);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stim
        logic [9:0] frame_a5;
        logic [39:0] cap;
        logic [39:0] expv;
        bit ok;
        bit seen_ready;
        bit seen_low;
        int fe0;
        int ov0;

        resetn   = 1'b0;
        rx_drv   = 1'b1;
        loop_en  = 1'b0;
        cts      = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_rts", rts, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_pulses", {rx_overrun, rx_frame_err}, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("rts_after_release", rts, 0);

        // 1: TX 0xA5 waveform, LSB first: start, 1,0,1,0,0,1,0,1, stop
        frame_a5 = 10'b1_10100101_0;
        for (int i = 0; i < 40; i++) expv[i] = frame_a5[i / 4];
        wait_ready(ok);
        check("t1_ready", ok, 1);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid   = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cap[i] = tx;
            if (tx_ready) seen_ready = 1'b1;
            @(negedge clk);
        end
        check("t1_waveform", cap[31:0], expv[31:0]);
        check("t1_waveform_hi", {24'h0, cap[39:32]}, {24'h0, expv[39:32]});
        check("t1_ready_low_40", seen_ready, 0);
        check("t1_ready_after", tx_ready, 1);
        $display("tx frame 0xA5 captured 0x%010h", cap);

        // 2: loopback 0x00, 0xFF, 0x3C
        loop_en = 1'b1;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        wait_ready(ok);
        check("t2_done", ok, 1);
        repeat (12) @(negedge clk);
        check("t2_rts_count3", rts, 1);
        pop_check("t2_b0", 8'h00);
        pop_check("t2_b1", 8'hFF);
        pop_check("t2_b2", 8'h3C);
        check("t2_empty", rx_valid, 0);
        check("t2_no_fe", fe_cnt - fe0, 0);
        check("t2_no_ov", ov_cnt - ov0, 0);
        loop_en = 1'b0;

        // 3: fill FIFO, watermark and overrun
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        check("t3_rts_count2", rts, 0);
        rx_frame(8'h33, 1'b1);
        check("t3_rts_count3", rts, 1);
        rx_frame(8'h44, 1'b1);
        check("t3_rts_count4", rts, 1);
        check("t3_ov_before", ov_cnt - ov0, 0);
        rx_frame(8'h55, 1'b1);
        check("t3_overrun", ov_cnt - ov0, 1);
        check("t3_no_fe", fe_cnt - fe0, 0);
        pop_check("t3_f1", 8'h11);
        pop_check("t3_f2", 8'h22);
        pop_check("t3_f3", 8'h33);
        pop_check("t3_f4", 8'h44);
        check("t3_empty", rx_valid, 0);
        check("t3_rts_low", rts, 0);

        // 4: stop bit 0
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx_frame(8'h5A, 1'b0);
        check("t4_frame_err", fe_cnt - fe0, 1);
        check("t4_no_ov", ov_cnt - ov0, 0);
        check("t4_rx_valid", rx_valid, 0);

        // 5: one-cycle glitch, then cts hold
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_glitch_valid", rx_valid, 0);
        check("t5_glitch_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        cts = 1'b1;
        repeat (4) @(negedge clk);
        tx_data    = 8'h96;
        tx_valid   = 1'b1;
        seen_ready = 1'b0;
        seen_low   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tx_ready) seen_ready = 1'b1;
            if (!tx)      seen_low   = 1'b1;
        end
        check("t5_cts_ready", seen_ready, 0);
        check("t5_cts_tx_idle", seen_low, 0);
        $display("cts held: ready_seen=%0d tx_low_seen=%0d", seen_ready, seen_low);
        cts = 1'b0;
        ok  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!tx) begin
                ok = 1'b1;
                break;
            end
        end
        tx_valid = 1'b0;
        check("t5_starts_after_cts", ok, 1);

        // 6: reset in the middle of the start bit
        @(negedge clk);
        check("t6_mid_start", tx, 0);
        resetn = 1'b0;
        #1;
        check("t6_tx_async", tx, 1);
        check("t6_rts_async", rts, 1);
        check("t6_ready_async", tx_ready, 0);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (60) @(negedge clk);
        check("t6_tx_idle", tx, 1);
        check("t6_rx_valid", rx_valid, 0);
        check("t6_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        $display("reset mid-frame: tx=%0d rts=%0d", tx, rts);

`ifdef HSM_UART_PARITY_EN
        // Parity: bad parity dropped, good parity accepted
        fe0 = fe_cnt;
        par_flip = 1'b1;
        rx_frame(8'h01, 1'b1);
        check("par_bad_fe", fe_cnt - fe0, 1);
        check("par_bad_valid", rx_valid, 0);
        par_flip = 1'b0;
        rx_frame(8'h01, 1'b1);
        check("par_good_fe", fe_cnt - fe0, 1);
        pop_check("par_good", 8'h01);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
